// File: rtl/myexp2_pkg.sv
// Shared types and constants for the fractional power-of-two unit.
// Holds the FSM state encoding and the C[k] = 2^(2^-k) table generator.
// The generator is only evaluated at elaboration time to build the constant ROM.
package myexp2_pkg;

  localparam int MANT_DEFAULT = 16;

  // Extra fraction bits carried while taking repeated square roots so the
  // final rounding to MANT bits is not disturbed by accumulated floor error.
  localparam int C_GUARD = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // round(2^(2^-k) * 2^mant), computed as k nested integer square roots of 2.0.
  // Indices outside 1..frac yield 1.0 so an idle lookup is harmless.
  function automatic logic [63:0] c_const(input int frac, input int mant, input int k);
    logic [127:0] v;
    logic [127:0] n;
    logic [127:0] r;
    logic [127:0] b;
    int           f;
    f = mant + C_GUARD;
    if (k < 1 || k > frac) begin
      return 64'd1 << mant;
    end
    v = 128'd2 << f;
    for (int s = 0; s < k; s++) begin
      // Bit-by-bit integer sqrt of v * 2^f keeps the result in the same scale.
      n = v << f;
      r = '0;
      b = 128'd1 << 126;
      for (int i = 0; i < 64; i++) begin
        if (n >= r + b) begin
          n = n - (r + b);
          r = (r >> 1) + b;
        end else begin
          r = r >> 1;
        end
        b = b >> 2;
      end
      v = r;
    end
    return 64'((v + (128'd1 << (C_GUARD - 1))) >> C_GUARD);
  endfunction

endpackage

// File: rtl/myexp2_const_rom.sv
// Constant table C[k] = 2^(2^-k) in Q1.MANT, indexed by the step number k.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup with no handshake.
module myexp2_const_rom
  import myexp2_pkg::*;
#(
  parameter int FRAC = 8,
  parameter int MANT = MANT_DEFAULT,
  parameter int KW   = $clog2(FRAC + 1)
) (
  input  logic [KW-1:0] i_k,
  output logic [MANT:0] o_c
);

  localparam int MW = MANT + 1;

  logic [MANT:0] w_tab [1:FRAC];

  for (genvar g = 1; g <= FRAC; g++) begin : g_tab
    localparam logic [63:0] CK = c_const(FRAC, MANT, g);
    assign w_tab[g] = CK[MANT:0];
  end

  // Select the entry for step i_k; anything outside 1..FRAC reads as 1.0.
  always_comb begin
    o_c = MW'(1) << MANT;
    for (int i = 1; i <= FRAC; i++) begin
      if (i_k == KW'(i)) begin
        o_c = w_tab[i];
      end
    end
  end

endmodule

// File: rtl/myexp2.sv
// Computes floor(2^(exp_int + exp_frac/2^FRAC)) by one mantissa multiply per fraction bit.
// Latency: out_valid exactly FRAC+1 cycles after the accepting edge, data independent.
// Backpressure: result held in DONE until out_ready; no new input accepted until then.
module myexp2
  import myexp2_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int FRAC      = 8,
  parameter  int MANT      = MANT_DEFAULT,
  localparam int IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_WIDTH-1:0] exp_int,
  input  logic [FRAC-1:0]      exp_frac,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     res
);

  localparam int KW = $clog2(FRAC + 1);
  localparam int MW = MANT + 1;
  localparam int PW = 2 * MW;
  // Wide enough for a Q1.MANT mantissa shifted by the largest exp_int.
  localparam int SW = MW + (1 << IDX_WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WIDTH-1:0] r_exp_int;
  logic [FRAC-1:0]      r_frac;
  logic [MANT:0]        r_mant;
  logic [KW-1:0]        r_k;
  logic [WIDTH-1:0]     r_res;
  logic [KW-1:0]        w_k_nxt;
  logic [MANT:0]        w_c;
  logic [MANT:0]        w_mant_step;
  logic [WIDTH-1:0]     w_res;
  logic                 w_last;

  assign w_k_nxt = r_k + KW'(1);
  // The extra cycle after step FRAC is spent registering the shifted result.
  assign w_last  = (r_k == KW'(FRAC));

  myexp2_const_rom #(
    .FRAC (FRAC),
    .MANT (MANT),
    .KW   (KW)
  ) u_rom (
    .i_k (w_k_nxt),
    .o_c (w_c)
  );

  // Single truncating (MANT+1)x(MANT+1) multiply; product stays below 2.0.
  assign w_mant_step = MW'((PW'(r_mant) * PW'(w_c)) >> MANT);
  assign w_res       = WIDTH'((SW'(r_mant) << r_exp_int) >> MANT);
  assign res         = r_res;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-bit mantissa refinement and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp_int <= '0;
      r_frac    <= '0;
      r_mant    <= MW'(1) << MANT;
      r_k       <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_exp_int <= exp_int;
            r_frac    <= exp_frac;
            r_mant    <= MW'(1) << MANT;
            r_k       <= '0;
          end
        end
        ST_CALC: begin
          if (w_last) begin
            r_res <= w_res;
          end else begin
            // Fraction bits are consumed MSB first, matching C[1], C[2], ...
            if (r_frac[FRAC-1]) begin
              r_mant <= w_mant_step;
            end
            r_frac <= r_frac << 1;
            r_k    <= w_k_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myexp2.sv
// Randomized and directed bench for myexp2 with a real-arithmetic reference model.
module tb_myexp2;

  localparam int WIDTH = 32;
  localparam int FRAC  = 8;
  localparam int MANT  = 16;
  localparam int IW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    exp_int;
  logic [FRAC-1:0]  exp_frac;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;

  int checks = 0;
  int errors = 0;

  // Monitor-side expectation state.
  bit              mon_en = 0;
  bit              m_busy = 0;
  int              m_age  = 0;
  longint unsigned m_exp  = 0;
  int              xfers  = 0;
  int              n_done = 0;

  myexp2 #(.WIDTH(WIDTH), .FRAC(FRAC), .MANT(MANT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_int   (exp_int),
    .exp_frac  (exp_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // C[k] from floating point: round(2^(2^-k) * 2^MANT).
  function automatic longint unsigned cval(input int k);
    real x;
    x = 2.0 ** (1.0 / (2.0 ** k));
    return longint'($rtoi(x * (2.0 ** MANT) + 0.5));
  endfunction

  function automatic longint unsigned model(input int e, input int f);
    longint unsigned m;
    m = longint'(1) << MANT;
    for (int k = 1; k <= FRAC; k++) begin
      if (((f >> (FRAC - k)) & 1) == 1) begin
        m = (m * cval(k)) >> MANT;
      end
    end
    return ((m << e) >> MANT) & 64'hFFFF_FFFF;
  endfunction

  // Per-cycle compare against the expected protocol and result, then predict the next edge.
  always @(negedge clk) begin
    bit exp_v;
    if (mon_en) begin
      exp_v = m_busy && (m_age >= FRAC + 1);
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) chk("res", res, m_exp);
      if (!rst_n) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1;
          m_age  = 0;
          m_exp  = model(int'(exp_int), int'(exp_frac));
        end
      end else if (exp_v) begin
        if (out_ready) begin
          m_busy = 0;
          xfers++;
        end
      end else begin
        m_age++;
      end
    end
  end

  task automatic op(input int e, input int f, input int hold,
                    output logic [WIDTH-1:0] got, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    exp_int  = IW'(e);
    exp_frac = FRAC'(f);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_int  = IW'($urandom);
    exp_frac = FRAC'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, FRAC + 1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    got = res;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_done++;
  endtask

  initial begin
    logic [WIDTH-1:0] got;
    int lat;
    int e;
    int f;
    int lg;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_int   = '0;
    exp_frac  = '0;

    // Pin the reference model with hand-derived values.
    chk("model_c1", cval(1), 92682);
    chk("model_0_0", model(0, 0), 1);
    chk("model_31_0", model(31, 0), 64'h8000_0000);
    chk("model_4_80", model(4, 8'h80), 22);
    chk("model_31_80", model(31, 8'h80), 64'hB505_0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    rst_n  = 1'b1;
    mon_en = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed corner cases.
    op(0, 0, 0, got, lat);
    chk("basic_res", got, 1);
    op(31, 0, 1, got, lat);
    chk("pow2_top", got, 32'h8000_0000);
    op(4, 8'h80, 0, got, lat);
    chk("half_step", got, 22);
    op(31, 8'h80, 2, got, lat);
    chk("top_range", got, 32'hB505_0000);
    op(4, 8'h80, 5, got, lat);
    chk("backpressure", got, 22);

    // Reset aborts an operation at CALC step 3.
    in_valid = 1'b1;
    exp_int  = IW'(9);
    exp_frac = FRAC'(8'h5A);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (15) begin
      @(posedge clk); #1;
    end

    // Randomized operands, with a log2 round trip for integral exponents.
    for (int t = 0; t < 60; t++) begin
      e = int'($urandom_range(0, WIDTH - 1));
      f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << FRAC) - 1));
      op(e, f, int'($urandom_range(0, 3)), got, lat);
      if (f == 0) begin
        lg = -1;
        for (int i = 0; i < WIDTH; i++) if (got[i]) lg = i;
        chk("log2_roundtrip", lg, e);
        chk("pow2_exact", got, longint'(1) << e);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("transfer_count", xfers, n_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
